// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL APB reconfiguration controller.
package pll_reconfig_pkg;

  localparam int unsigned APB_AW = 5;
  localparam int unsigned APB_DW = 16;
  localparam int unsigned CFG_W  = APB_AW + APB_DW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_SETUP,
    ST_ACCESS,
    ST_RELEASE,
    ST_WAIT_LOCK,
    ST_LOCKED
  } pll_state_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the PLL lock pin plus a registered falling-edge pulse.
module pll_lock_sync (
  input  logic apb_clk,
  input  logic apb_rst_n,
  input  logic lock,
  output logic lock_s,
  output logic lock_fall
);

  logic lock_meta;

  // lock_fall is high during the first cycle in which lock_s reads low.
  always_ff @(posedge apb_clk) begin
    if (!apb_rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      lock_fall <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep each stage one cycle behind the previous one.
      lock_meta <= lock;
      lock_s    <= lock_meta;
      lock_fall <= lock_s & ~lock_meta;
    end
  end

endmodule

// File: rtl/pll_apb_reconfig.sv
// APB initiator that holds the PLL in reset, writes a latched register table,
// releases reset and then waits for and monitors PLL lock.
module pll_apb_reconfig
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned NUM_WR        = 4,
  parameter int unsigned RST_CYC       = 16,
  parameter int unsigned READY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT  = 65535
) (
  input  logic                      apb_clk,
  input  logic                      apb_rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [NUM_WR*CFG_W-1:0]   cfg_words,
  output logic [APB_AW-1:0]         apb_addr,
  output logic                      apb_sel,
  output logic                      apb_en,
  output logic                      apb_write,
  output logic [APB_DW-1:0]         apb_wdata,
  input  logic                      apb_ready,
  output logic                      pll_rst,
  input  logic                      lock,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      lock_lost
);

  localparam int unsigned CNT_W = $clog2(max3(RST_CYC, READY_TIMEOUT, LOCK_TIMEOUT)) + 1;
  localparam int unsigned IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_WR - 1);

  pll_state_e                state, state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [NUM_WR*CFG_W-1:0]   cfg_tbl;
  logic [CFG_W-1:0]          cur_word;
  logic                      lock_s;
  logic                      lock_fall;
  logic                      accept;
  logic                      ready_to;
  logic                      lock_to;

  pll_lock_sync u_lock_sync (
    .apb_clk   (apb_clk),
    .apb_rst_n (apb_rst_n),
    .lock      (lock),
    .lock_s    (lock_s),
    .lock_fall (lock_fall)
  );

  assign accept   = cfg_valid & cfg_ready;
  assign ready_to = (state == ST_ACCESS)    && !apb_ready && (cnt == READY_LAST);
  assign lock_to  = (state == ST_WAIT_LOCK) && !lock_s    && (cnt == LOCK_LAST);
  assign cur_word = cfg_tbl[idx*CFG_W +: CFG_W];

  always_ff @(posedge apb_clk) begin
    if (!apb_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_LOCKED: if (accept) state_nxt = ST_RST_HOLD;
      ST_RST_HOLD:        if (cnt == RST_LAST) state_nxt = ST_SETUP;
      ST_SETUP:           state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (apb_ready)     state_nxt = (idx == IDX_LAST) ? ST_RELEASE : ST_SETUP;
        else if (ready_to) state_nxt = ST_IDLE;
      end
      ST_RELEASE:         state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s)       state_nxt = ST_LOCKED;
        else if (lock_to) state_nxt = ST_IDLE;
      end
      default:            state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    pll_rst   = 1'b0;
    apb_sel   = 1'b0;
    apb_en    = 1'b0;
    unique case (state)
      ST_IDLE, ST_LOCKED: cfg_ready = 1'b1;
      ST_RST_HOLD:        begin busy = 1'b1; pll_rst = 1'b1; end
      ST_SETUP:           begin busy = 1'b1; pll_rst = 1'b1; apb_sel = 1'b1; end
      ST_ACCESS:          begin busy = 1'b1; pll_rst = 1'b1; apb_sel = 1'b1; apb_en = 1'b1; end
      ST_RELEASE,
      ST_WAIT_LOCK:       busy = 1'b1;
      default:            cfg_ready = 1'b0;
    endcase
  end

  assign apb_write = apb_sel;
  assign apb_addr  = apb_sel ? cur_word[CFG_W-1:APB_DW] : '0;
  assign apb_wdata = apb_sel ? cur_word[APB_DW-1:0]     : '0;

  // NOTE: the table is pure data qualified by state, so it carries no reset.
  always_ff @(posedge apb_clk) begin
    if (accept) cfg_tbl <= cfg_words;
  end

  // Single counter reused for reset hold, PREADY wait and lock wait; it saturates at the compare.
  always_ff @(posedge apb_clk) begin
    if (!apb_rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      done <= (state == ST_WAIT_LOCK) && lock_s;

      unique case (state)
        ST_RST_HOLD:  cnt <= cnt + 1'b1;
        ST_ACCESS:    if (!apb_ready && cnt != READY_LAST) cnt <= cnt + 1'b1;
        ST_WAIT_LOCK: if (!lock_s && cnt != LOCK_LAST) cnt <= cnt + 1'b1;
        default:      cnt <= '0;
      endcase

      if (state == ST_ACCESS && apb_ready) idx <= idx + 1'b1;
      if (ready_to || lock_to)             err <= 1'b1;
      if (state == ST_LOCKED && lock_fall) lock_lost <= 1'b1;

      if (accept) begin
        cnt       <= '0;
        idx       <= '0;
        err       <= 1'b0;
        lock_lost <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pll_apb_reconfig.sv
// Directed bench for pll_apb_reconfig: reset, table writes, PREADY stall/timeout,
// lock timeout, lock loss, request while busy and mid-transfer reset.
module tb_pll_apb_reconfig;

  localparam int unsigned NUM_WR = 2;
  localparam int unsigned RST_CYC = 4;

  logic                 apb_clk = 1'b0;
  logic                 apb_rst_n = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [NUM_WR*21-1:0] cfg_words = '0;
  logic [4:0]           apb_addr;
  logic                 apb_sel;
  logic                 apb_en;
  logic                 apb_write;
  logic [15:0]          apb_wdata;
  logic                 apb_ready = 1'b1;
  logic                 pll_rst;
  logic                 lock = 1'b0;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 lock_lost;

  int checks = 0;
  int failures = 0;

  localparam logic [20:0] W0 = {5'h01, 16'h1234};
  localparam logic [20:0] W1 = {5'h02, 16'hABCD};
  localparam logic [20:0] W2 = {5'h03, 16'h0F0F};
  localparam logic [20:0] W3 = {5'h04, 16'hF0F0};
  localparam logic [20:0] W4 = {5'h0A, 16'h5555};
  localparam logic [20:0] W5 = {5'h0B, 16'hAAAA};

  pll_apb_reconfig #(
    .NUM_WR        (NUM_WR),
    .RST_CYC       (RST_CYC),
    .READY_TIMEOUT (8),
    .LOCK_TIMEOUT  (100)
  ) dut (
    .apb_clk   (apb_clk),
    .apb_rst_n (apb_rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_words (cfg_words),
    .apb_addr  (apb_addr),
    .apb_sel   (apb_sel),
    .apb_en    (apb_en),
    .apb_write (apb_write),
    .apb_wdata (apb_wdata),
    .apb_ready (apb_ready),
    .pll_rst   (pll_rst),
    .lock      (lock),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .lock_lost (lock_lost)
  );

  always #5 apb_clk = ~apb_clk;

  task automatic tick();
    @(posedge apb_clk);
    #1;
  endtask

  task automatic accept(input logic [20:0] w0, input logic [20:0] w1);
    cfg_words = {w1, w0};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_sel(output int n);
    n = 0;
    while (!apb_sel && n < 50) begin
      tick();
      n++;
    end
    if (!apb_sel) n = -1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    apb_rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({cfg_ready, busy, pll_rst, apb_sel, apb_en} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=10000", {cfg_ready, busy, pll_rst, apb_sel, apb_en});
    end
    checks++;
    if ({done, err, lock_lost, apb_write, apb_addr, apb_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_status got=%h exp=0", {done, err, lock_lost, apb_write, apb_addr, apb_wdata});
    end
    apb_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    apb_ready = 1'b1;
    lock = 1'b0;
    accept(W0, W1);
    checks++;
    if ({pll_rst, busy, cfg_ready} !== 3'b110) begin
      failures++;
      $display("FAIL basic_accept got=%b exp=110", {pll_rst, busy, cfg_ready});
    end
    wait_sel(n);
    checks++;
    if (n !== RST_CYC || pll_rst !== 1'b1) begin
      failures++;
      $display("FAIL basic_rst_hold got=%0d rst=%b exp=%0d rst=1", n, pll_rst, RST_CYC);
    end
    checks++;
    if ({apb_sel, apb_en, apb_write, apb_addr, apb_wdata} !== {3'b101, W0}) begin
      failures++;
      $display("FAIL basic_setup0 got=%h exp=%h", {apb_sel, apb_en, apb_write, apb_addr, apb_wdata}, {3'b101, W0});
    end
    tick();
    checks++;
    if ({apb_sel, apb_en, apb_write, apb_addr, apb_wdata} !== {3'b111, W0}) begin
      failures++;
      $display("FAIL basic_access0 got=%h exp=%h", {apb_sel, apb_en, apb_write, apb_addr, apb_wdata}, {3'b111, W0});
    end
    tick();
    checks++;
    if ({apb_sel, apb_en, apb_write, apb_addr, apb_wdata} !== {3'b101, W1}) begin
      failures++;
      $display("FAIL basic_setup1 got=%h exp=%h", {apb_sel, apb_en, apb_write, apb_addr, apb_wdata}, {3'b101, W1});
    end
    tick();
    checks++;
    if ({apb_sel, apb_en, apb_write, apb_addr, apb_wdata} !== {3'b111, W1}) begin
      failures++;
      $display("FAIL basic_access1 got=%h exp=%h", {apb_sel, apb_en, apb_write, apb_addr, apb_wdata}, {3'b111, W1});
    end
    tick();
    checks++;
    if ({pll_rst, apb_sel, busy} !== 3'b001) begin
      failures++;
      $display("FAIL basic_release got=%b exp=001", {pll_rst, apb_sel, busy});
    end
    repeat (20) tick();
    lock = 1'b1;
    wait_done(n);
    checks++;
    if (n < 2 || n > 3) begin
      failures++;
      $display("FAIL basic_done_latency got=%0d exp=2..3", n);
    end
    checks++;
    if ({busy, cfg_ready, err} !== 3'b010) begin
      failures++;
      $display("FAIL basic_locked got=%b exp=010", {busy, cfg_ready, err});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_lock_lost();
    lock = 1'b0;
    repeat (5) tick();
    lock = 1'b1;
    checks++;
    if ({lock_lost, cfg_ready, busy} !== 3'b110) begin
      failures++;
      $display("FAIL lost_set got=%b exp=110", {lock_lost, cfg_ready, busy});
    end
    repeat (5) tick();
    checks++;
    if ({lock_lost, done, cfg_ready} !== 3'b101) begin
      failures++;
      $display("FAIL lost_sticky got=%b exp=101", {lock_lost, done, cfg_ready});
    end
  endtask

  task automatic test_lock_timeout();
    int n;
    lock = 1'b0;
    accept(W2, W3);
    checks++;
    if ({lock_lost, err, busy} !== 3'b001) begin
      failures++;
      $display("FAIL lockto_accept_clear got=%b exp=001", {lock_lost, err, busy});
    end
    wait_sel(n);
    checks++;
    if (apb_addr !== 5'h03 || apb_wdata !== 16'h0F0F) begin
      failures++;
      $display("FAIL lockto_word0 got=%h_%h exp=03_0f0f", apb_addr, apb_wdata);
    end
    repeat (4) tick();
    checks++;
    if ({pll_rst, busy} !== 2'b01) begin
      failures++;
      $display("FAIL lockto_release got=%b exp=01", {pll_rst, busy});
    end
    tick();
    n = 0;
    while (!err && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 100) begin
      failures++;
      $display("FAIL lockto_cycles got=%0d exp=100", n);
    end
    checks++;
    if ({err, cfg_ready, busy, pll_rst} !== 4'b1100) begin
      failures++;
      $display("FAIL lockto_idle got=%b exp=1100", {err, cfg_ready, busy, pll_rst});
    end
  endtask

  task automatic test_err_clear();
    int n;
    lock = 1'b1;
    accept(W0, W1);
    checks++;
    if ({err, busy} !== 2'b01) begin
      failures++;
      $display("FAIL errclr_accept got=%b exp=01", {err, busy});
    end
    wait_done(n);
    checks++;
    if (n < 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL errclr_relock got=%0d err=%b exp=done err=0", n, err);
    end
  endtask

  task automatic test_ready_stall();
    int n;
    accept(W0, W1);
    wait_sel(n);
    apb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({apb_sel, apb_en, apb_addr, apb_wdata} !== {2'b11, W0}) begin
        failures++;
        $display("FAIL stall_hold%0d got=%h exp=%h", i, {apb_sel, apb_en, apb_addr, apb_wdata}, {2'b11, W0});
      end
      if (i == 3) apb_ready = 1'b1;
    end
    tick();
    checks++;
    if ({apb_sel, apb_en, apb_addr, apb_wdata, err} !== {2'b10, W1, 1'b0}) begin
      failures++;
      $display("FAIL stall_next got=%h exp=%h", {apb_sel, apb_en, apb_addr, apb_wdata, err}, {2'b10, W1, 1'b0});
    end
    wait_done(n);
    checks++;
    if (n < 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL stall_done got=%0d err=%b exp=done err=0", n, err);
    end
  endtask

  task automatic test_ignore_and_reset();
    int n;
    accept(W4, W5);
    wait_sel(n);
    apb_ready = 1'b0;
    tick();
    cfg_words = {W1, W0};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_ready, apb_en, apb_addr, apb_wdata} !== {2'b01, W4}) begin
      failures++;
      $display("FAIL busy_ignore got=%h exp=%h", {cfg_ready, apb_en, apb_addr, apb_wdata}, {2'b01, W4});
    end
    apb_ready = 1'b1;
    tick();
    checks++;
    if ({apb_sel, apb_en, apb_addr, apb_wdata} !== {2'b10, W5}) begin
      failures++;
      $display("FAIL busy_table got=%h exp=%h", {apb_sel, apb_en, apb_addr, apb_wdata}, {2'b10, W5});
    end
    tick();
    apb_rst_n = 1'b0;
    tick();
    checks++;
    if ({apb_sel, apb_en, pll_rst, busy, cfg_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL midreset got=%b exp=00001", {apb_sel, apb_en, pll_rst, busy, cfg_ready});
    end
    apb_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ready_timeout();
    int n;
    accept(W2, W3);
    wait_sel(n);
    apb_ready = 1'b0;
    tick();
    n = 0;
    while (!err && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL readyto_cycles got=%0d exp=8", n);
    end
    checks++;
    if ({err, apb_sel, pll_rst, cfg_ready, busy} !== 5'b10010) begin
      failures++;
      $display("FAIL readyto_idle got=%b exp=10010", {err, apb_sel, pll_rst, cfg_ready, busy});
    end
    apb_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_lock_lost();
    test_lock_timeout();
    test_err_clear();
    test_ready_stall();
    test_ignore_and_reset();
    test_ready_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
